// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch addresses are word aligned; the low two bits are simply dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction-memory side and core side.
// master = fetch unit, slave = memory + core environment.
interface fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {inst, pc} pairs.
// Flush wins over push and pop; push into a full queue is accepted only
// when a pop frees the head in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is 2^n.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while the queue reports empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !reset_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one-outstanding
// req/ack fetch from instruction memory, fetch queue toward the core, and
// redirect handling that flushes the queue and restarts at the target.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | nothing outstanding; issue at fetch_pc when the queue has room
//  WAIT  | request outstanding for the live stream; data goes into queue
//  DROP  | request outstanding for a flushed stream; data is thrown away
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk_i,
    input  logic         reset_i,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   START_PC = align_pc(RESET_PC);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;

    logic          ack;
    logic [31:0]   redirect_target;
    logic [31:0]   pc_inc;
    logic          q_push;
    logic          q_pop;
    logic          q_flush;
    logic [63:0]   q_rdata;
    logic [CW-1:0] q_count;
    logic [CW-1:0] count_after;
    logic          q_full;
    logic          q_empty;

    // An ack only counts while a request is actually on the bus.
    assign ack             = mem_req_q && bus.mem_ack;
    assign redirect_target = align_pc(bus.redirect_pc);
    assign pc_inc          = fetch_pc_q + PC_STEP;
    assign q_pop           = !q_empty && bus.inst_ready;
    assign q_flush         = bus.redirect;
    // Occupancy after this cycle's push (the word being acked) and pop.
    assign count_after     = q_count + CW'(1) - CW'(q_pop);

    // State, PC and memory-request registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= START_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= START_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Next-state, PC update, request issue and queue push decisions.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        q_push     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (!q_full) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                    if (ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (ack) begin
                    q_push     = 1'b1;
                    fetch_pc_d = pc_inc;
                    if (count_after < DEPTH_C) begin
                        // Back-to-back reissue keeps mem_req high with the
                        // next address, giving one word per cycle.
                        mem_addr_d = pc_inc;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end

            DROP: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .wdata_i ({bus.mem_rdata, mem_addr_q}),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = !q_empty;
    assign bus.inst       = q_empty ? 32'h0 : q_rdata[63:32];
    assign bus.inst_pc    = q_empty ? 32'h0 : q_rdata[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_w;

    fetch_unit_if bi ();
    fetch_unit_if bw ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .bus     (bi)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk_i   (clk),
        .reset_i (rst_w),
        .bus     (bw)
    );

    // Memory model for dut_a: ack after lat_a extra cycles, data = addr ^ KEY.
    int lat_a  = 0;
    int wcnt_a = 0;
    assign bi.mem_ack   = bi.mem_req && (wcnt_a == lat_a);
    assign bi.mem_rdata = bi.mem_addr ^ KEY;
    always @(posedge clk) begin
        if (rst_a || (bi.mem_req && bi.mem_ack)) wcnt_a <= 0;
        else if (bi.mem_req)                      wcnt_a <= wcnt_a + 1;
    end

    // Zero-wait memory for dut_w.
    assign bw.mem_ack   = bw.mem_req;
    assign bw.mem_rdata = bw.mem_addr ^ KEY;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] issued [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; lat_a = 0; bi.inst_ready = 1'b0; bi.redirect = 1'b0; bi.redirect_pc = '0;
        step(); step();
        checks++; if (bi.mem_req !== 1'b0)     begin errors++; $display("FAIL reset_mem_req: got %b want 0", bi.mem_req); end
        checks++; if (bi.mem_addr !== 32'h0)   begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bi.mem_addr); end
        checks++; if (bi.inst_valid !== 1'b0)  begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bi.inst_valid); end
        checks++; if (bi.inst !== 32'h0)       begin errors++; $display("FAIL reset_inst: got %h want 0", bi.inst); end
        checks++; if (bi.inst_pc !== 32'h0)    begin errors++; $display("FAIL reset_inst_pc: got %h want 0", bi.inst_pc); end
    endtask

    task automatic test_zero_wait();
        int cyc;
        logic [31:0] e;
        rst_a = 1'b1; lat_a = 0; bi.inst_ready = 1'b1; exp_q.delete();
        step();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        rst_a = 1'b0;
        step();
        checks++; if (bi.mem_req !== 1'b1 || bi.mem_addr !== 32'h0) begin errors++; $display("FAIL zw_first_req: req=%b addr=%h want 1/0", bi.mem_req, bi.mem_addr); end
        checks++; if (bi.inst_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_early: got %b want 0", bi.inst_valid); end
        step();
        checks++; if (bi.inst_valid !== 1'b1) begin errors++; $display("FAIL zw_first_valid: got %b want 1", bi.inst_valid); end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            if (bi.inst_valid && bi.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bi.inst_pc !== e || bi.inst !== (e ^ KEY)) begin
                    errors++; $display("FAIL zw_data: pc=%h inst=%h want pc=%h inst=%h", bi.inst_pc, bi.inst, e, e ^ KEY);
                end
            end
            step(); cyc++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zw_timeout: %0d words missing", exp_q.size()); end
        checks++; if (cyc != 8) begin errors++; $display("FAIL zw_throughput: 8 words took %0d cycles want 8", cyc); end
    endtask

    task automatic test_backpressure();
        logic prev_req, prev_ack;
        rst_a = 1'b1; lat_a = 3; bi.inst_ready = 1'b0; issued.delete();
        step(); step();
        rst_a = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bi.mem_req && (!prev_req || prev_ack)) issued.push_back(bi.mem_addr);
            prev_req = bi.mem_req; prev_ack = bi.mem_ack;
        end
        checks++; if (issued.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", issued.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= issued.size() || issued[i] !== 32'(i * 4)) begin
                errors++; $display("FAIL bp_req_addr%0d: got %h want %h", i, (i < issued.size()) ? issued[i] : 32'hx, 32'(i * 4));
            end
        end
        checks++; if (bi.mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b want 0", bi.mem_req); end
        checks++; if (bi.inst_valid !== 1'b1 || bi.inst_pc !== 32'h0 || bi.inst !== KEY) begin
            errors++; $display("FAIL bp_head: v=%b pc=%h inst=%h want 1/0/%h", bi.inst_valid, bi.inst_pc, bi.inst, KEY);
        end
        issued.delete();
        bi.inst_ready = 1'b1;
        step();
        bi.inst_ready = 1'b0;
        checks++; if (bi.inst_pc !== 32'h4) begin errors++; $display("FAIL bp_pop_head: got %h want 4", bi.inst_pc); end
        prev_req = bi.mem_req; prev_ack = bi.mem_ack;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bi.mem_req && (!prev_req || prev_ack)) issued.push_back(bi.mem_addr);
            prev_req = bi.mem_req; prev_ack = bi.mem_ack;
        end
        checks++; if (issued.size() != 1 || issued[0] !== 32'h10) begin
            errors++; $display("FAIL bp_refill: got %0d reqs first=%h want 1 req at 10", issued.size(), (issued.size() > 0) ? issued[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_drop();
        logic found, prev_req, prev_ack;
        logic [31:0] e;
        int cyc;
        rst_a = 1'b1; lat_a = 2; bi.inst_ready = 1'b0; exp_q.delete(); issued.delete();
        step(); step();
        rst_a = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (bi.mem_req && bi.mem_addr == 32'h8 && !bi.mem_ack) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rd_setup: request for 8 got %b want 1", found); end
        bi.redirect = 1'b1; bi.redirect_pc = 32'h100;
        step();
        bi.redirect = 1'b0;
        checks++; if (bi.inst_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: inst_valid=%b want 0", bi.inst_valid); end
        checks++; if (bi.mem_req !== 1'b1 || bi.mem_addr !== 32'h8) begin
            errors++; $display("FAIL rd_hold: req=%b addr=%h want 1/8", bi.mem_req, bi.mem_addr);
        end
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        bi.inst_ready = 1'b1;
        prev_req = bi.mem_req; prev_ack = bi.mem_ack;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            step(); cyc++;
            if (bi.mem_req && (!prev_req || prev_ack)) issued.push_back(bi.mem_addr);
            prev_req = bi.mem_req; prev_ack = bi.mem_ack;
            if (bi.inst_valid && bi.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bi.inst_pc !== e || bi.inst !== (e ^ KEY)) begin
                    errors++; $display("FAIL rd_data: pc=%h inst=%h want pc=%h inst=%h", bi.inst_pc, bi.inst, e, e ^ KEY);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rd_timeout: %0d words missing", exp_q.size()); end
        checks++; if (issued.size() == 0 || issued[0] !== 32'h100) begin
            errors++; $display("FAIL rd_next_addr: got %h want 100", (issued.size() > 0) ? issued[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_ack();
        logic found;
        logic [31:0] e;
        int cyc;
        rst_a = 1'b1; lat_a = 1; bi.inst_ready = 1'b0; exp_q.delete();
        step(); step();
        rst_a = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (bi.mem_req && bi.mem_ack && bi.mem_addr == 32'h4) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL ra_setup: ack for 4 got %b want 1", found); end
        bi.redirect = 1'b1; bi.redirect_pc = 32'h203;
        step();
        bi.redirect = 1'b0;
        checks++; if (bi.inst_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: inst_valid=%b want 0", bi.inst_valid); end
        checks++; if (bi.mem_req !== 1'b0) begin errors++; $display("FAIL ra_no_drop: mem_req=%b want 0", bi.mem_req); end
        step();
        checks++; if (bi.mem_req !== 1'b1 || bi.mem_addr !== 32'h200) begin
            errors++; $display("FAIL ra_next_addr: req=%b addr=%h want 1/200", bi.mem_req, bi.mem_addr);
        end
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        bi.inst_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            step(); cyc++;
            if (bi.inst_valid && bi.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bi.inst_pc !== e || bi.inst !== (e ^ KEY)) begin
                    errors++; $display("FAIL ra_data: pc=%h inst=%h want pc=%h inst=%h", bi.inst_pc, bi.inst, e, e ^ KEY);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ra_timeout: %0d words missing", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        int cyc;
        rst_w = 1'b1; bw.inst_ready = 1'b1; bw.redirect = 1'b0; bw.redirect_pc = '0; exp_q.delete();
        step();
        checks++; if (bw.mem_req !== 1'b0 || bw.mem_addr !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL wrap_reset: req=%b addr=%h want 0/fffffff8", bw.mem_req, bw.mem_addr);
        end
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
        rst_w = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            step(); cyc++;
            if (bw.inst_valid && bw.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bw.inst_pc !== e || bw.inst !== (e ^ KEY)) begin
                    errors++; $display("FAIL wrap_data: pc=%h inst=%h want pc=%h inst=%h", bw.inst_pc, bw.inst, e, e ^ KEY);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d words missing", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic found;
        logic [31:0] e;
        int acks, cyc;
        rst_a = 1'b1; lat_a = 3; bi.inst_ready = 1'b0; exp_q.delete();
        step(); step();
        rst_a = 1'b0;
        found = 1'b0; acks = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            step();
            if (bi.mem_req && bi.mem_ack) acks++;
            else if (acks == 2 && bi.mem_req) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rm_setup: third request got %b want 1", found); end
        rst_a = 1'b1;
        step();
        checks++; if (bi.mem_req !== 1'b0)    begin errors++; $display("FAIL rm_req: got %b want 0", bi.mem_req); end
        checks++; if (bi.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", bi.inst_valid); end
        checks++; if (bi.mem_addr !== 32'h0)  begin errors++; $display("FAIL rm_addr: got %h want 0", bi.mem_addr); end
        step();
        rst_a = 1'b0;
        step();
        checks++; if (bi.mem_req !== 1'b1 || bi.mem_addr !== 32'h0) begin
            errors++; $display("FAIL rm_restart: req=%b addr=%h want 1/0", bi.mem_req, bi.mem_addr);
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        bi.inst_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            step(); cyc++;
            if (bi.inst_valid && bi.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bi.inst_pc !== e || bi.inst !== (e ^ KEY)) begin
                    errors++; $display("FAIL rm_data: pc=%h inst=%h want pc=%h inst=%h", bi.inst_pc, bi.inst, e, e ^ KEY);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_timeout: %0d words missing", exp_q.size()); end
    endtask

    initial begin
        rst_a = 1'b1; rst_w = 1'b1;
        bi.inst_ready = 1'b0; bi.redirect = 1'b0; bi.redirect_pc = '0;
        bw.inst_ready = 1'b0; bw.redirect = 1'b0; bw.redirect_pc = '0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the cpu core.
- Generates sequential PCs and fetches instruction words from a variable-latency instruction memory over a req/ack handshake.
- Buffers the fetched words in a small queue and presents {inst, inst_pc} to the core over a valid/ready interface.
- Branch/jump redirect from the core flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, >= 2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  word-aligned fetch address
- mem_ack  in  1  memory completes request; mem_rdata valid this cycle
- mem_rdata  in  32  instruction word returned
- redirect  in  1  core requests fetch restart (taken branch/jump)
- redirect_pc  in  32  restart address
- inst_valid  out  1  queue head valid
- inst_ready  in  1  core accepts head this cycle
- inst  out  32  instruction at queue head
- inst_pc  out  32  PC of instruction at queue head

Behaviour:
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, queue empty, fetch_pc=RESET_PC, FSM=IDLE.
- Clock and reset: one clock; reset is synchronous and active-high. Reset mid-transaction abandons the request. The memory shares the same reset and drops its transaction too.
- Memory handshake:
  - At most one outstanding request.
  - mem_req and mem_addr are held stable from assertion until the mem_ack cycle.
  - Transfer completes in the cycle where mem_req && mem_ack.
  - mem_ack while mem_req=0 is ignored.
- FSM states:
  - IDLE: issue when (count + 0) < DEPTH and no redirect. Drive mem_req=1 and mem_addr=fetch_pc, then go to WAIT.
  - WAIT: on ack, push {mem_rdata, mem_addr} into the queue and set fetch_pc += 4. If space remains after push and pop accounting, issue the next request back-to-back in the following cycle (stay WAIT); otherwise go to IDLE.
  - DROP: request in flight belongs to a flushed stream. Keep mem_req/mem_addr unchanged. On ack, discard the data and go to IDLE (fetch resumes at the redirect target).
- Space check counts the in-flight word: issue only if count + outstanding < DEPTH.
- Latency:
  - First mem_req is asserted in the cycle after reset deasserts.
  - Ack in cycle T gives inst_valid=1 with that word in cycle T+1.
  - Zero-wait memory (ack in the cycle req is first seen) sustains 1 instruction per 2 cycles minimum. Back-to-back reissue gives 1 per cycle when ack is immediate.
- Queue: inst, inst_pc and inst_valid come from the head entry. Pop when inst_valid && inst_ready. Simultaneous push and pop at full capacity is legal; count is unchanged.
- Redirect (highest priority):
  - Queue is flushed in the same edge; inst_valid=0 in the next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
  - If WAIT and no ack in this cycle, go to DROP.
  - If ack coincides with redirect, discard the data and go to IDLE.
  - Redirect together with a pop: the pop is honoured by the core and the queue is flushed anyway.
  - Redirect during DROP updates fetch_pc again and stays in DROP.
- Arithmetic: fetch_pc increments by 4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. mem_addr[1:0] is always 00.

Decomposition:
- Package fetch_pkg: state enum {IDLE, WAIT, DROP}, PC_STEP=4, default RESET_PC constant.
- Sub-module fetch_queue: synchronous FIFO (DEPTH x 64 bits) with push, pop, synchronous flush, count, full, empty. Flush has priority over push.
- FSM and PC logic live in fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning mem[a]=a^32'hA5A5_0000 with inst_ready=1 → inst_pc sequence 0,4,8,C… in order; inst matches; first inst_valid 2 cycles after reset release.
- Memory ack latency 3 cycles, inst_ready=0 → exactly 4 requests issued (0x0–0xC), mem_req stays 0 while full. Then assert inst_ready for 1 cycle → one new request to 0x10 issued.
- Redirect to 0x100 while request for 0x8 is outstanding (ack 2 cycles later) → queue empty the next cycle, 0x8 data discarded, next mem_addr=0x100, first inst_pc=0x100.
- Redirect to 0x203 coinciding with mem_ack → ack data not enqueued, next mem_addr=0x200, no DROP cycle.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory → inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset while in WAIT with queue holding 2 entries → next cycle mem_req=0, inst_valid=0, mem_addr=RESET_PC. After release, fetch restarts at RESET_PC.
